// File: rtl/rand_nibble_packer_pkg.sv
// Shared constants and width helpers for the random-nibble packer slice.
package rand_pkg;

  localparam int unsigned NIB_W = 4;

  // Output word width for a given nibble count.
  function automatic int unsigned word_w(input int unsigned nibbles);
    return NIB_W * nibbles;
  endfunction

  // Width of a level counter able to hold 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of an index/pointer over n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rand_nibble_packer_fifo.sv
// Show-ahead synchronous word FIFO with explicit level tracking.
module rand_word_fifo
  import rand_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic                      clr,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PW = idx_w(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = empty ? '0 : mem_q[rd_q];

  // Accept handshakes; a push at full is only taken when a pop frees the slot.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (clr) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level state.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  // Storage array; contents are don't-care while empty, so it has no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/rand_nibble_packer.sv
// Packs done-flag-qualified LFSR nibbles into words and buffers them for a
// valid/ready consumer; words arriving at a full buffer are dropped.
module rand_nibble_packer
  import rand_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic [NIB_W-1:0]            nib_in,
  input  logic                        nib_done,
  input  logic                        flush,
  output logic [word_w(NIBBLES)-1:0]  word_out,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic [lvl_w(DEPTH)-1:0]     level,
  output logic                        overflow
);

  localparam int unsigned WW = word_w(NIBBLES);
  localparam int unsigned IW = idx_w(NIBBLES);

  logic          done_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [WW-1:0] part_q, part_d;
  logic          ovf_q, ovf_d;

  logic          cap, last, push, pop;
  logic          fifo_full, fifo_empty;
  logic [WW-1:0] merged;

  // Edge-detect the done flag and merge the incoming nibble at the current index.
  always_comb begin
    cap    = nib_done & ~done_q;
    last   = (idx_q == IW'(NIBBLES - 1));
    merged = part_q;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (idx_q == IW'(k)) merged[NIB_W*k +: NIB_W] = nib_in;
    end
    push = cap & last;
    pop  = ~fifo_empty & word_ready;
  end

  // Assembler and overflow next-state; flush wins over everything else.
  always_comb begin
    idx_d  = idx_q;
    part_d = part_q;
    ovf_d  = ovf_q;
    if (flush) begin
      idx_d  = '0;
      part_d = '0;
      ovf_d  = 1'b0;
    end else if (cap) begin
      if (last) begin
        idx_d  = '0;
        part_d = '0;
        if (fifo_full && !pop) ovf_d = 1'b1;
      end else begin
        idx_d  = idx_q + IW'(1);
        part_d = merged;
      end
    end
  end

  // Assembler state; done_q samples the flag even during a flush.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      done_q <= 1'b0;
      idx_q  <= '0;
      part_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= nib_done;
      idx_q  <= idx_d;
      part_q <= part_d;
      ovf_q  <= ovf_d;
    end
  end

  rand_word_fifo #(
    .WIDTH (WW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .clr   (flush),
    .push  (push),
    .pop   (pop),
    .din   (merged),
    .dout  (word_out),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign word_valid = ~fifo_empty;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_rand_nibble_packer.sv
// Directed bench for rand_nibble_packer (NIBBLES=4, DEPTH=4).
module tb_rand_nibble_packer;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic [3:0]  nib_in = '0;
  logic        nib_done = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [2:0]  level;
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  rand_nibble_packer #(
    .NIBBLES (4),
    .DEPTH   (4)
  ) dut (
    .clk        (clk),
    .res        (res),
    .nib_in     (nib_in),
    .nib_done   (nib_done),
    .flush      (flush),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .level      (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  nib;
    logic        done;
    logic        rdy;
    logic [15:0] w;
    logic        v;
    logic [2:0]  lvl;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] nib, input logic done, input logic rdy,
                     input logic [15:0] w, input logic v, input logic [2:0] lvl,
                     input logic ovf);
    vec_t r;
    r.nib = nib; r.done = done; r.rdy = rdy;
    r.w = w; r.v = v; r.lvl = lvl; r.ovf = ovf;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] w, input logic v,
                         input logic [2:0] lvl, input logic ovf);
    chk({name, ".word_out"},   32'(word_out),   32'(w));
    chk({name, ".word_valid"}, 32'(word_valid), 32'(v));
    chk({name, ".level"},      32'(level),      32'(lvl));
    chk({name, ".overflow"},   32'(overflow),   32'(ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulses for each nibble, LSB nibble first; rdy_last drives
  // word_ready during the edge that captures the final nibble.
  task automatic send_word(input logic [15:0] w, input logic rdy_last);
    for (int k = 0; k < 4; k++) begin
      nib_in     = w[4*k +: 4];
      nib_done   = 1'b1;
      word_ready = (k == 3) ? rdy_last : 1'b0;
      tick();
      nib_done   = 1'b0;
      word_ready = 1'b0;
      tick();
    end
  endtask

  task automatic pop_expect(input string name, input logic [15:0] w);
    chk(name, 32'(word_out), 32'(w));
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    // Table: apply inputs, clock once, compare outputs just after the edge.
    add(4'h8, 1, 0, 16'h0000, 0, 0, 0);
    add(4'h8, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h5, 1, 0, 16'h0000, 0, 0, 0);
    add(4'h5, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h2, 1, 0, 16'h0000, 0, 0, 0);
    add(4'h2, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h9, 1, 0, 16'h9258, 1, 1, 0);
    add(4'h9, 0, 0, 16'h9258, 1, 1, 0);
    add(4'h0, 0, 1, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(4'hA, 1, 0, 16'h0000, 0, 0, 0);
    add(4'hA, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h1, 1, 0, 16'h0000, 0, 0, 0);
    add(4'h1, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h2, 1, 0, 16'h0000, 0, 0, 0);
    add(4'h2, 0, 0, 16'h0000, 0, 0, 0);
    add(4'h3, 1, 0, 16'h321A, 1, 1, 0);
    add(4'h3, 0, 1, 16'h0000, 0, 0, 0);

    // Reset state, observed while reset is held.
    tick();
    chk_all("reset", 16'h0000, 0, 0, 0);
    #2 res = 1'b1;
    tick();

    foreach (vecs[i]) begin
      nib_in     = vecs[i].nib;
      nib_done   = vecs[i].done;
      word_ready = vecs[i].rdy;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].w, vecs[i].v, vecs[i].lvl, vecs[i].ovf);
    end
    nib_done = 1'b0; word_ready = 1'b0;

    // Fill, then overflow on the fifth word.
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'h3333, 0);
    send_word(16'h4444, 0);
    chk_all("fill4", 16'h1111, 1, 4, 0);
    send_word(16'h5555, 0);
    chk_all("ovf", 16'h1111, 1, 4, 1);
    pop_expect("ovf_pop0", 16'h1111);
    pop_expect("ovf_pop1", 16'h2222);
    pop_expect("ovf_pop2", 16'h3333);
    pop_expect("ovf_pop3", 16'h4444);
    chk_all("ovf_drained", 16'h0000, 0, 0, 1);

    // Flush clears the sticky overflow.
    flush = 1'b1; tick(); flush = 1'b0;
    chk_all("flush_ovf", 16'h0000, 0, 0, 0);

    // Push and pop together while full.
    send_word(16'h1111, 0);
    send_word(16'h2222, 0);
    send_word(16'h3333, 0);
    send_word(16'h4444, 0);
    send_word(16'hBEEF, 1);
    chk_all("full_pushpop", 16'h2222, 1, 4, 0);
    pop_expect("pp_pop0", 16'h2222);
    pop_expect("pp_pop1", 16'h3333);
    pop_expect("pp_pop2", 16'h4444);
    pop_expect("pp_pop3", 16'hBEEF);
    chk_all("pp_drained", 16'h0000, 0, 0, 0);

    // Flush mid-word discards the partial nibbles.
    nib_in = 4'h7; nib_done = 1'b1; tick(); nib_done = 1'b0; tick();
    nib_in = 4'h6; nib_done = 1'b1; tick(); nib_done = 1'b0; tick();
    flush = 1'b1; tick(); flush = 1'b0;
    send_word(16'h4321, 0);
    chk_all("flush_mid", 16'h4321, 1, 1, 0);
    pop_expect("flush_pop", 16'h4321);

    // Asynchronous reset mid-word with two words buffered.
    send_word(16'h1357, 0);
    send_word(16'h2468, 0);
    nib_in = 4'hF; nib_done = 1'b1; tick(); nib_done = 1'b0; tick();
    nib_in = 4'hE; nib_done = 1'b1; tick(); nib_done = 1'b0; tick();
    chk_all("pre_reset", 16'h1357, 1, 2, 0);
    #3 res = 1'b0;
    #1 chk_all("async_reset", 16'h0000, 0, 0, 0);
    @(posedge clk);
    #2 res = 1'b1;
    send_word(16'hCAFE, 0);
    chk_all("post_reset", 16'hCAFE, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
